// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through a registered carry, with
// start/busy/done handshake and unsigned carry / signed overflow flags.
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state;
  logic [IdxW-1:0]  idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [WIDTH-1:0] work;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_r;
  logic             chunk_c;
  logic             msb_cin;
  logic [WIDTH-1:0] work_nxt;

  // Operands shift right each cycle so the live chunk always sits in the low bits;
  // results enter the working register from the top.
  always_comb begin
    chunk_a              = opa[CHUNK-1:0];
    chunk_b              = opb[CHUNK-1:0];
    {chunk_c, chunk_r}   = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK+1)'(carry);
    work_nxt             = WIDTH'({chunk_r, work} >> CHUNK);
    // Carry into the MSB recovered from the MSB's own sum bit.
    msb_cin              = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_r[CHUNK-1];
  end

  assign busy = (state == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            opa   <= x;
            opb   <= y ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            idx   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          opa   <= opa >> CHUNK;
          opb   <= opb >> CHUNK;
          carry <= chunk_c;
          work  <= work_nxt;
          idx   <= idx + 1'b1;
          if (idx == LastIdx) begin
            sum   <= work_nxt;
            cout  <= chunk_c;
            ovf   <= msb_cin ^ chunk_c;
            done  <= 1'b1;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Parametrised, multi-cycle add/subtract unit built around a registered carry chain. It consumes CHUNK bits per clock, so a WIDTH-bit operation takes WIDTH/CHUNK cycles. It reports unsigned carry and signed overflow, and uses a start/busy/done handshake. It is the sequential, area-trimmed successor to the team's combinational full-adder cells, for datapaths where adder area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state immediately.
- start  input  1  request a new operation; sampled only when idle.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- x  input  WIDTH  first operand; latched with start.
- y  input  WIDTH  second operand; latched with start.
- cin  input  1  carry-in (add) or borrow-in (subtract); latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB.
- ovf  output  1  two's-complement overflow.

## Operation
- Let N = WIDTH/CHUNK. States:
  - IDLE: waits for start.
  - RUN: holds a chunk index 0..N-1.
- IDLE to RUN:
  - Transition occurs when start=1 at a clock edge.
  - On that edge, latch x; latch y XOR {WIDTH{sub}}; initialise the carry register to cin XOR sub.
  - Set the index to 0 and raise busy.
- Add: sum = x + y + cin (mod 2^WIDTH).
- Subtract: sum = x − y − cin (mod 2^WIDTH).
  - cout is the raw carry: 1 means no borrow; for cin=0 that is x ≥ y unsigned.
- RUN, each edge:
  - Add chunk [idx·CHUNK +: CHUNK] of the latched operands plus the carry register.
  - Write the CHUNK result bits into the working result register.
  - Store the chunk carry-out in the carry register and increment idx.
- On the edge that processes chunk N−1:
  - sum ← working result, with the final chunk included.
  - cout ← carry out of bit WIDTH−1.
  - ovf ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - done ← 1, busy ← 0, and the state returns to IDLE.
- sum, cout and ovf change only on the done edge, and hold until the next done edge. Intermediate chunks are never visible on sum.
- start is ignored while busy=1; operand changes during RUN have no effect.
- start may be asserted in the done cycle (state is IDLE then); it is accepted normally, giving back-to-back operation with no bubble beyond the done cycle.
- For CHUNK = WIDTH (N=1): the operation completes on the first RUN edge.

## Timing
- Reset values (rst_n low, asynchronous): busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; all internal registers 0.
- Reset mid-operation: the operation is abandoned immediately. No done follows, and the outputs stay 0 until a new operation completes.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy is high from E0 until edge E0+N.
  - done and valid results appear at edge E0+N; done is high for exactly one cycle.
  - Start-to-done latency is N cycles.
- Throughput: one operation per N+1 cycles when start is held high continuously (start is re-accepted in each done cycle).
- busy and done are never high together.

## Test plan
- WIDTH=16, CHUNK=4, add 0x1234+0x0FED, cin=0 -> sum=0x2221, cout=0, ovf=0. done pulses exactly 4 cycles after the start edge; busy is high for those 4 cycles.
- Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Add 0xFFFF+0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
- Subtract:
  - 0x0005−0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0010−0x0001, cin=1 -> sum=0x000E, cout=1.
- Issue start with A=0x0001, B=0x0001, then re-pulse start with other operands while busy -> result is 0x0002 (the new operands are ignored). Assert start in the done cycle with 0x00FF+0x0001 -> second done exactly 4 cycles later with sum=0x0100.
- Drop rst_n low two cycles into an operation -> busy, done, sum, cout and ovf read 0 immediately with no clock edge, and no done follows. A fresh operation after reset completes correctly.
- Parameter sweep over (16,1), (16,16) and (32,8), with 1000 random x/y/cin/sub each -> sum, cout and ovf match the reference arithmetic; latency equals WIDTH/CHUNK.
